// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receive FSM states, prefix bytes, decoded-code record.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ps2_code_t;

  // Odd parity holds when the 8 data bits plus the parity bit carry an odd count of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-FF synchronisers on both pins, glitch filter on the clock,
// and a one-cycle pulse on each filtered falling clock edge with the data sample
// captured alongside it.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_clk,
  input  logic raw_data,
  output logic fall,
  output logic data_s
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  // Idle bus is high, so syncs and filter start high to avoid a false edge out of reset.
  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          fall_q, fall_d;
  logic          data_q;

  // Synchronise both raw pins into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], raw_clk};
      data_sync_q <= {data_sync_q[0], raw_data};
    end
  end

  // Filtered clock flips only on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  // Filter state, edge pulse and the data bit that belongs to that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
      fall_q <= 1'b0;
      data_q <= 1'b1;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      fall_q <= fall_d;
      data_q <= data_sync_q[1];
    end
  end

  assign fall   = fall_q;
  assign data_s = data_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver. Decodes 11-bit frames into scan codes, folds the
// E0/F0 prefixes into flags, and presents results on a valid/ready output register.
// "release" is a reserved word in SystemVerilog, so the break flag port is release_flag.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 48_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       extended,
  output logic       release_flag,
  output logic       valid,
  input  logic       ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int TMO_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW         = $clog2(TMO_CYCLES + 1);

  logic fall, data_s;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .reset    (reset),
    .raw_clk  (ps2_clk),
    .raw_data (ps2_data),
    .fall     (fall),
    .data_s   (data_s)
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          ext_q, ext_d;
  logic          rel_q, rel_d;
  logic [TW-1:0] tmo_q, tmo_d;
  ps2_code_t     out_q, out_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          emit;
  ps2_code_t     emit_code;

  // Frame FSM, shift register, timeout and prefix flags; advanced only by filtered falls.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    ferr_d    = 1'b0;
    emit      = 1'b0;
    emit_code = '{code: shift_q, ext: ext_q, rel: rel_q};

    // Saturating gap counter, held at zero while idle and restarted by every edge.
    if (state_q == IDLE || fall)       tmo_d = '0;
    else if (tmo_q == TW'(TMO_CYCLES)) tmo_d = tmo_q;
    else                               tmo_d = tmo_q + 1'b1;

    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d = DATA;
            bcnt_d  = '0;
          end
        end
        DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_s && ps2_parity_ok(shift_q, par_q)) begin
            if (shift_q == PS2_PREFIX_EXT)      ext_d = 1'b1;
            else if (shift_q == PS2_PREFIX_REL) rel_d = 1'b1;
            else begin
              emit  = 1'b1;
              ext_d = 1'b0;
              rel_d = 1'b0;
            end
          end else begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TMO_CYCLES)) begin
      ferr_d  = 1'b1;
      state_d = IDLE;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
    end
  end

  // Output register: a held result is never overwritten; a blocked code raises overrun.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (emit) begin
      if (!valid_q || ready) begin
        out_d   = emit_code;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      tmo_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      tmo_q   <= tmo_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign code         = out_q.code;
  assign extended     = out_q.ext;
  assign release_flag = out_q.rel;
  assign valid        = valid_q;
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: clean frames, prefixes, parity error, timeout,
// backpressure/overrun, clock glitches and mid-frame reset.
module tb_ps2_frame_rx;

  // Scaled clock so the timeout is 200 cycles: 2 MHz * 100 us.
  localparam int CLK_HZ = 2_000_000;
  localparam int TMO_US = 100;
  localparam int HALF   = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] code;
  logic       extended, release_flag, valid, frame_error, overrun;

  int checks = 0;
  int failures = 0;

  // Monitor tallies (written only by the monitor).
  int         n_vld = 0, n_ferr = 0, n_ovr = 0;
  logic [7:0] last_code = '0;
  logic       last_ext = 1'b0, last_rel = 1'b0;
  int         b_vld, b_ferr, b_ovr;

  ps2_frame_rx #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TMO_US), .FILTER_LEN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .code         (code),
    .extended     (extended),
    .release_flag (release_flag),
    .valid        (valid),
    .ready        (ready),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Sample on the falling edge: record handshakes and error/overrun pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (valid && ready) begin
        n_vld     <= n_vld + 1;
        last_code <= code;
        last_ext  <= extended;
        last_rel  <= release_flag;
      end
      if (frame_error) n_ferr <= n_ferr + 1;
      if (overrun)     n_ovr  <= n_ovr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    cyc(1);
    b_vld  = n_vld;
    b_ferr = n_ferr;
    b_ovr  = n_ovr;
  endtask

  // Low pulse on ps2_clk lasting two system clocks.
  task automatic glitch();
    ps2_clk = 1'b0;
    cyc(2);
    ps2_clk = 1'b1;
  endtask

  // Send the first nbits of a frame; glitch_bit >= 0 adds a clock glitch in that bit's high phase.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits,
                            input int glitch_bit);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (i == glitch_bit) begin
        cyc(3);
        glitch();
        cyc(HALF - 5);
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(30);
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_code", 32'(code), 0);
    chk("rst_ferr", 32'(frame_error), 0);
    chk("rst_ovr", 32'(overrun), 0);
    reset = 1'b1;
    cyc(10);

    // 1: clean 0x1C
    mark();
    send_frame(8'h1C, 0, 11, -1);
    chk("t1_count", 32'(n_vld - b_vld), 1);
    chk("t1_code", 32'(last_code), 32'h1C);
    chk("t1_flags", 32'({last_ext, last_rel}), 0);
    chk("t1_ferr", 32'(n_ferr - b_ferr), 0);

    // 2: E0 F0 74 folds into one code, then plain 74
    mark();
    send_frame(8'hE0, 0, 11, -1);
    send_frame(8'hF0, 0, 11, -1);
    chk("t2_prefix_silent", 32'(n_vld - b_vld), 0);
    send_frame(8'h74, 0, 11, -1);
    chk("t2_count", 32'(n_vld - b_vld), 1);
    chk("t2_code", 32'(last_code), 32'h74);
    chk("t2_flags", 32'({last_ext, last_rel}), 32'b11);
    send_frame(8'h74, 0, 11, -1);
    chk("t2b_code", 32'(last_code), 32'h74);
    chk("t2b_flags", 32'({last_ext, last_rel}), 0);

    // 3: E0 then bad parity clears the prefix; next 1B decodes plain
    mark();
    send_frame(8'hE0, 0, 11, -1);
    send_frame(8'h1C, 1, 11, -1);
    chk("t3_ferr", 32'(n_ferr - b_ferr), 1);
    chk("t3_no_valid", 32'(n_vld - b_vld), 0);
    send_frame(8'h1B, 0, 11, -1);
    chk("t3_code", 32'(last_code), 32'h1B);
    chk("t3_flags", 32'({last_ext, last_rel}), 0);

    // 4: clock stops after start + 5 data bits
    mark();
    send_frame(8'h29, 0, 6, -1);
    cyc(400);
    chk("t4_ferr", 32'(n_ferr - b_ferr), 1);
    chk("t4_no_valid", 32'(n_vld - b_vld), 0);
    send_frame(8'h29, 0, 11, -1);
    chk("t4_code", 32'(last_code), 32'h29);
    chk("t4_ferr_after", 32'(n_ferr - b_ferr), 1);

    // 5: backpressure and overrun
    mark();
    ready = 1'b0;
    send_frame(8'h15, 0, 11, -1);
    chk("t5_valid", 32'(valid), 1);
    chk("t5_code", 32'(code), 32'h15);
    send_frame(8'h16, 0, 11, -1);
    chk("t5_ovr", 32'(n_ovr - b_ovr), 1);
    chk("t5_hold", 32'(code), 32'h15);
    chk("t5_ferr", 32'(n_ferr - b_ferr), 0);
    ready = 1'b1;
    cyc(1);
    chk("t5_drop", 32'(valid), 0);
    cyc(20);
    chk("t5_count", 32'(n_vld - b_vld), 1);
    chk("t5_last", 32'(last_code), 32'h15);

    // 6: glitches idle and mid-frame
    mark();
    glitch();
    cyc(20);
    send_frame(8'h5A, 0, 11, 4);
    chk("t6_code", 32'(last_code), 32'h5A);
    chk("t6_count", 32'(n_vld - b_vld), 1);
    chk("t6_ferr", 32'(n_ferr - b_ferr), 0);

    // 6b: reset mid-frame
    send_frame(8'h99, 0, 4, -1);
    reset = 1'b0;
    cyc(3);
    chk("t6_rst_code", 32'(code), 0);
    chk("t6_rst_valid", 32'(valid), 0);
    reset = 1'b1;
    cyc(20);
    mark();
    send_frame(8'h33, 0, 11, -1);
    chk("t6_post_code", 32'(last_code), 32'h33);
    chk("t6_post_ferr", 32'(n_ferr - b_ferr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
